// File: rtl/jive_alu_pkg.sv
// jive_alu_pkg: op codes, compare conditions, FSM states and parameter checks for jive_alu_seq.
package jive_alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_CMP  = 4'b0010;
    localparam logic [3:0] OP_SET  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_ANDN = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_PASS = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [2:0] F3_EQ   = 3'b000;
    localparam logic [2:0] F3_NE   = 3'b001;
    localparam logic [2:0] F3_LT   = 3'b100;
    localparam logic [2:0] F3_GE   = 3'b101;
    localparam logic [2:0] F3_LTU  = 3'b110;
    localparam logic [2:0] F3_GEU  = 3'b111;
    typedef enum logic [1:0] {IDLE, ARITH, SHIFT, DONE} state_e;
    function automatic bit dw_legal(int dw);
        return dw == 8 || dw == 16 || dw == 32;
    endfunction
    function automatic bit sh_legal(int sh);
        return sh == 1 || sh == 2 || sh == 4 || sh == 8 || sh == 16;
    endfunction
endpackage

// File: rtl/jive_alu_if.sv
// jive_alu_if: request/result bundle between the core and jive_alu_seq.
interface jive_alu_if;
    logic        req_vld;
    logic        req_rdy;
    logic [3:0]  op;
    logic [2:0]  func3;
    logic [31:0] x_op;
    logic [31:0] y_op;
    logic        res_vld;
    logic [31:0] res;
    logic        res_branch;
    modport master (output req_vld, op, func3, x_op, y_op, input req_rdy, res_vld, res, res_branch);
    modport slave  (input req_vld, op, func3, x_op, y_op, output req_rdy, res_vld, res, res_branch);
endinterface

// File: rtl/jive_alu_slice.sv
// jive_alu_slice: one DW-bit slice of adder, logic unit and zero-detect with carry chaining.
module jive_alu_slice #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    input  logic          sub,
    input  logic [2:0]    op,
    output logic [DW-1:0] y,
    output logic          cout,
    output logic          zero,
    output logic          ovf
);
    logic [DW-1:0] bb, s, lg;
    assign bb = sub ? ~b : b;
    assign {cout, s} = {1'b0, a} + {1'b0, bb} + {{DW{1'b0}}, cin};
    assign lg = op[1:0] == 2'b00 ? a ^ b : op[1:0] == 2'b01 ? a & ~b : op[1:0] == 2'b10 ? a | b : a & b;
    assign y = op[2] ? lg : s;
    assign zero = s == '0;
    assign ovf = (a[DW-1] == bb[DW-1]) && (s[DW-1] != a[DW-1]);
endmodule

// File: rtl/jive_alu_seq.sv
// jive_alu_seq: self-sequencing 32-bit ALU, LS slice first for arithmetic, SH_STEP bits/cycle for shifts.
module jive_alu_seq
    import jive_alu_pkg::*;
#(
    parameter int DW = 16,
    parameter int SH_STEP = 1
) (
    input logic clk,
    input logic rst,
    jive_alu_if.slave bus
);
    localparam int N = 32 / DW;
    if (!dw_legal(DW) || !sh_legal(SH_STEP)) begin : g_bad_param
        $error("jive_alu_seq: illegal DW or SH_STEP");
    end
    state_e state, state_n;
    logic [3:0] op_r;
    logic [2:0] f3_r, k;
    logic [31:0] x_r, y_r, acc, res_q, fresh, sra_v;
    logic [4:0] rem, rem_n, step;
    logic carry_r, eq_r, sign_r, ovf_r, br_q, sub, last, lt, cond, is_cmp;
    logic [DW-1:0] sl_y;
    logic sl_c, sl_z, sl_v;
    assign sub = ~op_r[2] & |op_r[1:0];
    jive_alu_slice #(.DW(DW)) u_slice (
        .a(x_r[DW-1:0]), .b(y_r[DW-1:0]), .cin(k == 3'd0 ? sub : carry_r), .sub(sub),
        .op(op_r[2:0]), .y(sl_y), .cout(sl_c), .zero(sl_z), .ovf(sl_v)
    );
    assign last = k == 3'(N - 1);
    assign step = rem < 5'(SH_STEP) ? rem : 5'(SH_STEP);
    assign rem_n = rem - step;
    assign sra_v = $signed(x_r) >>> step;
    assign lt = sign_r ^ ovf_r;
    // func3 010/011 alias the signed/unsigned less-than conditions
    assign cond = f3_r == F3_EQ ? eq_r : f3_r == F3_NE ? ~eq_r :
                  (f3_r == F3_LT || f3_r == 3'b010) ? lt : f3_r == F3_GE ? ~lt :
                  (f3_r == F3_LTU || f3_r == 3'b011) ? ~carry_r : carry_r;
    assign is_cmp = op_r == OP_CMP || op_r == OP_SET;
    assign fresh = op_r[3] ? x_r : op_r == OP_SET ? {31'b0, cond} : acc;
    assign bus.req_rdy = state == IDLE;
    assign bus.res_vld = state == DONE;
    assign bus.res = state == DONE ? fresh : res_q;
    assign bus.res_branch = state == DONE ? is_cmp & cond : br_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = bus.req_vld ? (bus.op[3] ? SHIFT : ARITH) : IDLE;
            ARITH: state_n = last ? DONE : ARITH;
            SHIFT: state_n = rem_n == 5'd0 ? DONE : SHIFT;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= '0; f3_r <= '0; x_r <= '0; y_r <= '0; acc <= '0; res_q <= '0;
            k <= '0; rem <= '0; carry_r <= 1'b0; eq_r <= 1'b0; sign_r <= 1'b0; ovf_r <= 1'b0; br_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_vld) begin
                    op_r <= bus.op;
                    f3_r <= bus.func3;
                    x_r <= bus.x_op;
                    y_r <= bus.y_op;
                    k <= '0;
                    eq_r <= 1'b1;
                    rem <= bus.op[1:0] == 2'b00 ? 5'd0 : bus.y_op[4:0];
                end
                // operands drain low slice first, result fills in from the top
                ARITH: begin
                    x_r <= x_r >> DW;
                    y_r <= y_r >> DW;
                    acc <= (acc >> DW) | (32'(sl_y) << (32 - DW));
                    carry_r <= sl_c;
                    eq_r <= eq_r & sl_z;
                    sign_r <= sl_y[DW-1];
                    ovf_r <= sl_v;
                    k <= k + 3'd1;
                end
                SHIFT: begin
                    rem <= rem_n;
                    x_r <= op_r[1:0] == 2'b01 ? x_r << step : op_r[1:0] == 2'b11 ? sra_v : x_r >> step;
                end
                DONE: begin
                    res_q <= fresh;
                    br_q <= is_cmp & cond;
                end
                default: ;
            endcase
        end
    end
endmodule
